// File: rtl/csa_accum_sched_pkg.sv
// Shared constants for the CSA accumulation frame scheduler.
//   ST_*          : scheduler state encodings (3-bit, legacy-compatible constants)
//   TREE_LAT_DEF  : default adder-tree latency, tree input to valid vs/vc at the CPA
package csa_accum_sched_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    localparam int TREE_LAT_DEF = 2;

endpackage

// File: rtl/csa_accum_sched_if.sv
// Bundle between the frame controller / target IP side and the scheduler.
//   Control  : start, frame_len, abort          (master -> slave)
//   Input    : in_valid, in_cges -> in_ready    (valid/ready handshake)
//   Tree side: cges_out, cal, clr_acc, acc_en   (slave -> master)
//   Status   : beat_cnt, busy, done             (slave -> master)
// The scheduler connects through the slave modport; the driver/observer uses master.
interface csa_accum_sched_if #(
    parameter int CGES    = 13,
    parameter int FRAME_W = 16
);
    logic               start;
    logic [FRAME_W-1:0] frame_len;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [CGES-2:0]    in_cges;
    logic [CGES-2:0]    cges_out;
    logic               cal;
    logic               clr_acc;
    logic               acc_en;
    logic [FRAME_W-1:0] beat_cnt;
    logic               busy;
    logic               done;

    modport master (
        output start, frame_len, abort, in_valid, in_cges,
        input  in_ready, cges_out, cal, clr_acc, acc_en, beat_cnt, busy, done
    );

    modport slave (
        input  start, frame_len, abort, in_valid, in_cges,
        output in_ready, cges_out, cal, clr_acc, acc_en, beat_cnt, busy, done
    );
endinterface

// File: rtl/csa_accum_sched_valid_pipe.sv
// Issue-valid delay line: follows cal through the adder-tree latency so the
// CPA result register is enabled exactly when its vs/vc are valid.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous flush of every in-flight beat
//   i_vld      : issue valid (cal)
//   o_vld      : issue valid delayed LAT cycles (acc_en)
//   o_drained  : no beat sits behind the output stage, so after this cycle
//                the line is empty even if o_vld is still high now
module csa_accum_sched_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_vld,
    output logic o_vld,
    output logic o_drained
);

    logic [LAT-1:0] r_vld_pipe;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    assign o_vld = r_vld_pipe[LAT-1];

    // Looking one stage ahead of the output lets the scheduler raise done in
    // the cycle right after the last acc_en instead of one cycle later.
    generate
        if (LAT == 1) begin : g_lat1
            assign o_drained = 1'b1;
        end else begin : g_latn
            assign o_drained = ~|r_vld_pipe[LAT-2:0];
        end
    endgenerate

endmodule

// File: rtl/csa_accum_sched.sv
// Frame scheduler for the CSA adder-tree -> CPA -> result-register datapath.
// Runs a length-bounded frame: clears the accumulator, pulls frame_len cges
// vectors from the target IP over valid/ready, issues one per cycle to the
// tree (cal + registered cges_out), enables the CPA result register TREE_LAT
// cycles after each issue and pulses done once the last result has landed.
//   clk, reset : clock, synchronous active-high reset
//   bus        : csa_accum_sched_if slave (control, input handshake, tree
//                outputs, status)
// Parameters: CGES inputs (vector width CGES-1), BITS accuracy (accumulator is
// $clog2(CGES)+BITS wide downstream), TREE_LAT tree latency, FRAME_W counters.
module csa_accum_sched
    import csa_accum_sched_pkg::*;
#(
    parameter int CGES     = 13,
    parameter int BITS     = 32,
    parameter int TREE_LAT = TREE_LAT_DEF,
    parameter int FRAME_W  = 16
) (
    input logic              clk,
    input logic              reset,
    csa_accum_sched_if.slave bus
);

    generate
        if (TREE_LAT < 1 || BITS < 1 || CGES < 2) begin : g_param_chk
            $error("csa_accum_sched: CGES>=2, BITS>=1 and TREE_LAT>=1 required");
        end
    endgenerate

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [FRAME_W-1:0] r_len;
    logic [FRAME_W-1:0] r_beat_cnt;
    logic [CGES-2:0]    r_cges;
    logic               r_cal;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_start_ok;
    logic               w_acc_en;
    logic               w_drained;

    // abort kills the handshake in the very cycle it is raised
    assign w_in_ready = (r_state == ST_RUN) && !bus.abort;
    assign w_accept   = w_in_ready && bus.in_valid;
    // beat_cnt < r_len while in RUN, so the increment cannot wrap
    assign w_last     = w_accept && ((r_beat_cnt + FRAME_W'(1)) == r_len);
    assign w_start_ok = (r_state == ST_IDLE) && bus.start && !bus.abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // A zero-length frame goes through DRAIN: nothing is in flight
            // there, so done follows two cycles after start with no clear.
            ST_IDLE:  if (bus.start) w_state_nxt = (bus.frame_len == '0) ? ST_DRAIN : ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_cal && w_drained) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (bus.abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_cges     <= '0;
            r_cal      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cal   <= w_accept;
            if (w_accept) r_cges <= bus.in_cges;
            if (w_start_ok) r_len <= bus.frame_len;
            if (w_start_ok && bus.frame_len == '0) begin
                r_beat_cnt <= '0;
            end else if (r_state == ST_CLEAR && !bus.abort) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + FRAME_W'(1);
            end
        end
    end

    csa_accum_sched_valid_pipe #(
        .LAT (TREE_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (bus.abort),
        .i_vld     (r_cal),
        .o_vld     (w_acc_en),
        .o_drained (w_drained)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.cges_out = r_cges;
    assign bus.cal      = r_cal;
    assign bus.clr_acc  = (r_state == ST_CLEAR);
    assign bus.acc_en   = w_acc_en;
    assign bus.beat_cnt = r_beat_cnt;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_csa_accum_sched.sv
// Scoreboard bench: each directed frame pushes its hand-computed output events
// (cycle, data) into per-kind queues; a negedge monitor pops and compares every
// clr_acc / cal / acc_en / done pulse and every busy edge the DUT produces.
module tb_csa_accum_sched;

    localparam int CGES     = 13;
    localparam int BITS     = 32;
    localparam int TREE_LAT = 2;
    localparam int FRAME_W  = 16;

    localparam int K_CLR  = 0;
    localparam int K_CAL  = 1;
    localparam int K_ACC  = 2;
    localparam int K_DONE = 3;
    localparam int K_BSY  = 4;

    typedef struct {
        int cyc;
        int data;
    } ev_t;

    ev_t  evq [5][$];
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic prev_busy = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   b;

    csa_accum_sched_if #(.CGES(CGES), .FRAME_W(FRAME_W)) ifc ();

    csa_accum_sched #(
        .CGES     (CGES),
        .BITS     (BITS),
        .TREE_LAT (TREE_LAT),
        .FRAME_W  (FRAME_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic string kname(input int k);
        case (k)
            K_CLR:   return "clr_acc";
            K_CAL:   return "cal";
            K_ACC:   return "acc_en";
            K_DONE:  return "done";
            default: return "busy_edge";
        endcase
    endfunction

    task automatic exp_ev(input int k, input int c, input int d);
        ev_t e;
        e.cyc  = c;
        e.data = d;
        evq[k].push_back(e);
    endtask

    task automatic got(input int k, input int d);
        ev_t e;
        n_chk++;
        if (evq[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event at cycle %0d data 'h%0h", kname(k), cyc, d);
        end else begin
            e = evq[k].pop_front();
            if (e.cyc != cyc || e.data != d) begin
                n_fail++;
                $display("FAIL %s: got cycle %0d data 'h%0h, required cycle %0d data 'h%0h",
                         kname(k), cyc, d, e.cyc, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.clr_acc)           got(K_CLR, 0);
            if (ifc.cal)               got(K_CAL, int'(ifc.cges_out));
            if (ifc.acc_en)            got(K_ACC, 0);
            if (ifc.done)              got(K_DONE, int'(ifc.beat_cnt));
            if (ifc.busy !== prev_busy) got(K_BSY, int'(ifc.busy));
            prev_busy = ifc.busy;
        end
    end

    // Drives one frame starting in the current cycle (offset 0). in_cges at
    // offset i is 'hA00+i, so a beat accepted at offset k shows as cal data 'hA00+k.
    task automatic run(input int len, input logic [31:0] vpat, input int ncyc,
                       input int abort_at, input int restart_at);
        for (int i = 0; i < ncyc; i++) begin
            ifc.start     = (i == 0) || (i == restart_at);
            ifc.frame_len = (i == restart_at) ? 16'd7 : 16'(len);
            ifc.abort     = (i == abort_at);
            ifc.in_valid  = vpat[i % 32];
            ifc.in_cges   = 12'(32'hA00 + i);
            @(posedge clk); #1;
        end
        ifc.start    = 1'b0;
        ifc.abort    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_cges  = '0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // frame_len=3, in_valid held high
    task automatic exp_len3(input int t);
        exp_ev(K_CLR, t + 1, 0);
        exp_ev(K_BSY, t + 1, 1);
        exp_ev(K_CAL, t + 3, 'hA02);
        exp_ev(K_CAL, t + 4, 'hA03);
        exp_ev(K_CAL, t + 5, 'hA04);
        exp_ev(K_ACC, t + 5, 0);
        exp_ev(K_ACC, t + 6, 0);
        exp_ev(K_ACC, t + 7, 0);
        exp_ev(K_DONE, t + 8, 3);
        exp_ev(K_BSY, t + 9, 0);
    endtask

    initial begin
        ifc.start     = 1'b1;
        ifc.frame_len = 16'd3;
        ifc.abort     = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_cges   = 12'hFFF;

        // reset held 3 cycles with start asserted
        repeat (3) begin
            @(negedge clk);
            chk("reset_cges_out", int'(ifc.cges_out), 0);
            chk("reset_ctrl_outs", int'({ifc.cal, ifc.clr_acc, ifc.acc_en, ifc.busy,
                                         ifc.done, ifc.in_ready, ifc.beat_cnt}), 0);
        end
        @(posedge clk); #1;
        reset        = 1'b0;
        ifc.start    = 1'b0;
        ifc.in_valid = 1'b0;
        gap(2);

        // basic frame
        b = cyc; exp_len3(b);
        run(3, 32'hFFFF_FFFF, 12, -1, -1);
        gap(2);

        // back-pressure: in_valid 1,0,1,0...
        b = cyc;
        exp_ev(K_CLR, b + 1, 0);
        exp_ev(K_BSY, b + 1, 1);
        exp_ev(K_CAL, b + 3, 'hA02);
        exp_ev(K_CAL, b + 5, 'hA04);
        exp_ev(K_CAL, b + 7, 'hA06);
        exp_ev(K_CAL, b + 9, 'hA08);
        exp_ev(K_ACC, b + 5, 0);
        exp_ev(K_ACC, b + 7, 0);
        exp_ev(K_ACC, b + 9, 0);
        exp_ev(K_ACC, b + 11, 0);
        exp_ev(K_DONE, b + 12, 4);
        exp_ev(K_BSY, b + 13, 0);
        run(4, 32'h5555_5555, 16, -1, -1);
        gap(2);

        // zero-length frame: in_valid high must not cause any issue
        b = cyc;
        exp_ev(K_BSY, b + 1, 1);
        exp_ev(K_DONE, b + 2, 0);
        exp_ev(K_BSY, b + 3, 0);
        run(0, 32'hFFFF_FFFF, 6, -1, -1);
        gap(2);

        // abort after the second accept
        b = cyc;
        exp_ev(K_CLR, b + 1, 0);
        exp_ev(K_BSY, b + 1, 1);
        exp_ev(K_CAL, b + 3, 'hA02);
        exp_ev(K_CAL, b + 4, 'hA03);
        exp_ev(K_BSY, b + 5, 0);
        run(5, 32'hFFFF_FFFF, 10, 4, -1);
        @(negedge clk);
        chk("abort_beat_cnt_hold", int'(ifc.beat_cnt), 2);
        chk("abort_idle_busy", int'(ifc.busy), 0);
        gap(1);

        // full frame after abort, frame_len=2
        b = cyc;
        exp_ev(K_CLR, b + 1, 0);
        exp_ev(K_BSY, b + 1, 1);
        exp_ev(K_CAL, b + 3, 'hA02);
        exp_ev(K_CAL, b + 4, 'hA03);
        exp_ev(K_ACC, b + 5, 0);
        exp_ev(K_ACC, b + 6, 0);
        exp_ev(K_DONE, b + 7, 2);
        exp_ev(K_BSY, b + 8, 0);
        run(2, 32'hFFFF_FFFF, 11, -1, -1);
        gap(2);

        // start while busy (frame_len=7 at offset 3) is ignored
        b = cyc; exp_len3(b);
        run(3, 32'hFFFF_FFFF, 12, -1, 3);
        gap(2);

        // start + abort in the same idle cycle: nothing happens
        run(3, 32'h0, 1, 0, -1);
        @(negedge clk);
        chk("start_abort_busy", int'(ifc.busy), 0);
        gap(1);
        @(negedge clk);
        chk("start_abort_busy2", int'(ifc.busy), 0);
        chk("start_abort_beat_cnt", int'(ifc.beat_cnt), 3);
        gap(4);

        for (int k = 0; k < 5; k++) begin
            chk({"missing_", kname(k)}, evq[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
